// File: rtl/gate_pkg.sv
// Shared definitions for the gate-op arbiter: op codes, op width and legality check.
package gate_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_INV  = 3'd0,
    OP_AND  = 3'd1,
    OP_NAND = 3'd2,
    OP_MUX  = 3'd3,
    OP_NOR  = 3'd4
  } op_e;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/gate_op_arbiter_gates.sv
// Bit-parallel gate cells shared by all requesters of gate_op_arbiter.
module gate_inv #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = ~a;
endmodule

module gate_and2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a & b;
endmodule

module gate_nand2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a & b);
endmodule

module gate_mux2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

module gate_nor2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/gate_op_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping at N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   w_idx;
  logic w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap keeps non-power-of-2 N correct without a modulo operator.
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = IW'(w_idx);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin sharing of one gate datapath among NREQ requesters, with a
// single-entry registered output stage and a saturating completion counter.
module gate_op_arbiter
  import gate_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       in_valid,
  output logic [NREQ-1:0]       in_ready,
  input  logic [NREQ*3-1:0]     in_op,
  input  logic [NREQ*WIDTH-1:0] in_a,
  input  logic [NREQ*WIDTH-1:0] in_b,
  input  logic [NREQ-1:0]       in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_err,
  output logic [31:0]           done_cnt
);

  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [IDW-1:0]   r_out_id;
  logic             r_out_err;
  logic [IDW-1:0]   r_ptr;
  logic [31:0]      r_done_cnt;

  logic [OPW-1:0]   w_op_arr [NREQ];
  logic [WIDTH-1:0] w_a_arr  [NREQ];
  logic [WIDTH-1:0] w_b_arr  [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op_arr[gi] = in_op[gi*OPW +: OPW];
      assign w_a_arr[gi]  = in_a[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi]  = in_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic             w_can_accept;
  logic             w_arb_en;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_grant;

  assign w_can_accept = !r_out_valid || out_ready;
  // Gating with rst_n keeps in_ready low while reset is held.
  assign w_arb_en     = w_can_accept && rst_n;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req     (in_valid),
    .en      (w_arb_en),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_grant  = |w_gnt;
  assign in_ready = w_gnt;

  logic [OPW-1:0]   w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_sel;

  assign w_op  = w_op_arr[w_gnt_idx];
  assign w_a   = w_a_arr[w_gnt_idx];
  assign w_b   = w_b_arr[w_gnt_idx];
  assign w_sel = in_sel[w_gnt_idx];

  logic [WIDTH-1:0] w_inv_y;
  logic [WIDTH-1:0] w_and_y;
  logic [WIDTH-1:0] w_nand_y;
  logic [WIDTH-1:0] w_mux_y;
  logic [WIDTH-1:0] w_nor_y;

  gate_inv   #(.W(WIDTH)) u_inv  (.a(w_a), .y(w_inv_y));
  gate_and2  #(.W(WIDTH)) u_and  (.a(w_a), .b(w_b), .y(w_and_y));
  gate_nand2 #(.W(WIDTH)) u_nand (.a(w_a), .b(w_b), .y(w_nand_y));
  gate_mux2  #(.W(WIDTH)) u_mux  (.a(w_a), .b(w_b), .sel(w_sel), .y(w_mux_y));
  gate_nor2  #(.W(WIDTH)) u_nor  (.a(w_a), .b(w_b), .y(w_nor_y));

  logic [WIDTH-1:0] w_result;
  logic             w_err;

  always_comb begin
    w_result = '0;
    w_err    = !op_legal(w_op);
    case (w_op)
      OP_INV:  w_result = w_inv_y;
      OP_AND:  w_result = w_and_y;
      OP_NAND: w_result = w_nand_y;
      OP_MUX:  w_result = w_mux_y;
      OP_NOR:  w_result = w_nor_y;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_err   <= 1'b0;
      r_ptr       <= '0;
      r_done_cnt  <= '0;
    end else begin
      // A grant implies can_accept, so any current result retires at this same edge.
      if (w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_id    <= w_gnt_idx;
        r_out_err   <= w_err;
        r_ptr       <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + IDW'(1);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready && (r_done_cnt != 32'hFFFF_FFFF)) begin
        r_done_cnt <= r_done_cnt + 32'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_err   = r_out_err;
  assign done_cnt  = r_done_cnt;

endmodule
